// File: rtl/vga_pkg.sv
// Shared definitions for the VGA timing generator.
// Holds the 640x480@60 default timing, the counter widths and the FSM state type.
// The optional frame counter is enabled by defining VGA_TIMING_FRAME_CNT_EN.
package vga_pkg;

   localparam int unsigned COUNT_W     = 10;
   localparam int unsigned FRAME_CNT_W = 16;

   // 640x480@60 horizontal timing, in pixels
   localparam int unsigned DEF_H_ACTIVE = 640;
   localparam int unsigned DEF_H_FP     = 16;
   localparam int unsigned DEF_H_SYNC   = 96;
   localparam int unsigned DEF_H_BP     = 48;

   // 640x480@60 vertical timing, in lines
   localparam int unsigned DEF_V_ACTIVE = 480;
   localparam int unsigned DEF_V_FP     = 10;
   localparam int unsigned DEF_V_SYNC   = 2;
   localparam int unsigned DEF_V_BP     = 33;

   typedef enum logic {
      WAIT_LOCK = 1'b0,
      RUN       = 1'b1
   } vga_state_e;

endpackage : vga_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single-bit level crossing into clk_i.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, clears both flops
//   d_i   - asynchronous input level
//   q_o   - synchronized level
module sync_2ff (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync_2ff

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, sync and active decode,
// frame start pulse and an optional completed-frame counter.
// Counting only runs while the synchronized MMCM lock is high.
// Ports:
//   pixel_clk   - pixel clock, only clock of the block
//   reset       - synchronous active-high reset
//   locked      - MMCM lock, asynchronous to pixel_clk
//   hsync/vsync - sync outputs, asserted level set by HSYNC_POL/VSYNC_POL
//   active      - pixel lies in the visible region
//   h_count     - horizontal position 0..H_TOTAL-1
//   v_count     - vertical position 0..V_TOTAL-1
//   frame_start - one-cycle pulse at h_count=0, v_count=0
//   frame_count - completed frames; constant 0 unless VGA_TIMING_FRAME_CNT_EN is defined
// All outputs are registered and describe the same h_count/v_count.
module vga_timing_gen
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
   parameter int unsigned H_FP      = DEF_H_FP,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_BP      = DEF_H_BP,
   parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
   parameter int unsigned V_FP      = DEF_V_FP,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_BP      = DEF_V_BP,
   parameter logic        HSYNC_POL = 1'b0,
   parameter logic        VSYNC_POL = 1'b0
) (
   input  logic                   pixel_clk,
   input  logic                   reset,
   input  logic                   locked,
   output logic                   hsync,
   output logic                   vsync,
   output logic                   active,
   output logic [COUNT_W-1:0]     h_count,
   output logic [COUNT_W-1:0]     v_count,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_count
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [COUNT_W-1:0] H_LAST   = COUNT_W'(H_TOTAL - 1);
   localparam logic [COUNT_W-1:0] V_LAST   = COUNT_W'(V_TOTAL - 1);
   localparam logic [COUNT_W-1:0] H_ACT_C  = COUNT_W'(H_ACTIVE);
   localparam logic [COUNT_W-1:0] V_ACT_C  = COUNT_W'(V_ACTIVE);
   localparam logic [COUNT_W-1:0] HS_BEG_C = COUNT_W'(H_ACTIVE + H_FP);
   localparam logic [COUNT_W-1:0] HS_END_C = COUNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [COUNT_W-1:0] VS_BEG_C = COUNT_W'(V_ACTIVE + V_FP);
   localparam logic [COUNT_W-1:0] VS_END_C = COUNT_W'(V_ACTIVE + V_FP + V_SYNC);

   logic locked_s;

   vga_state_e         state_q, state_d;
   logic [COUNT_W-1:0] h_q, h_d;
   logic [COUNT_W-1:0] v_q, v_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               active_q, active_d;
   logic               fs_q, fs_d;
   logic               run_d;

   // Lock crosses from the MMCM domain
   sync_2ff u_lock_sync (
      .clk_i (pixel_clk),
      .rst_i (reset),
      .d_i   (locked),
      .q_o   (locked_s)
   );

   // State and output registers; reset wins over every other update
   always_ff @(posedge pixel_clk) begin
      if (reset) begin
         state_q  <= WAIT_LOCK;
         h_q      <= '0;
         v_q      <= '0;
         hsync_q  <= ~HSYNC_POL;
         vsync_q  <= ~VSYNC_POL;
         active_q <= 1'b0;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         h_q      <= h_d;
         v_q      <= v_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         active_q <= active_d;
         fs_q     <= fs_d;
      end
   end

   // Next state, next counts, and decode of the next counts so outputs stay aligned
   always_comb begin
      state_d = state_q;
      h_d     = '0;
      v_d     = '0;

      case (state_q)
         WAIT_LOCK: begin
            if (locked_s) state_d = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_d = WAIT_LOCK;
            end else if (h_q == H_LAST) begin
               h_d = '0;
               v_d = (v_q == V_LAST) ? '0 : v_q + COUNT_W'(1);
            end else begin
               h_d = h_q + COUNT_W'(1);
               v_d = v_q;
            end
         end
         default: state_d = WAIT_LOCK;
      endcase

      run_d    = (state_d == RUN);
      hsync_d  = (run_d && (h_d >= HS_BEG_C) && (h_d < HS_END_C)) ? HSYNC_POL : ~HSYNC_POL;
      vsync_d  = (run_d && (v_d >= VS_BEG_C) && (v_d < VS_END_C)) ? VSYNC_POL : ~VSYNC_POL;
      active_d = run_d && (h_d < H_ACT_C) && (v_d < V_ACT_C);
      fs_d     = run_d && (h_d == '0) && (v_d == '0);
   end

`ifdef VGA_TIMING_FRAME_CNT_EN
   logic [FRAME_CNT_W-1:0] fc_q, fc_d;
   logic                   frame_wrap;

   // Only a wrap inside RUN counts; the pulse on entry from WAIT_LOCK does not
   assign frame_wrap = (state_q == RUN) && locked_s && (h_q == H_LAST) && (v_q == V_LAST);
   assign fc_d       = frame_wrap ? fc_q + FRAME_CNT_W'(1) : fc_q;

   always_ff @(posedge pixel_clk) begin
      if (reset) fc_q <= '0;
      else       fc_q <= fc_d;
   end

   assign frame_count = fc_q;
`else
   assign frame_count = '0;
`endif

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign active      = active_q;
   assign h_count     = h_q;
   assign v_count     = v_q;
   assign frame_start = fs_q;

endmodule : vga_timing_gen
